// File: rtl/muldiv_sched.sv
// Two-port arbiter/sequencer sharing one iterative mul/div engine.
// Define MULDIV_SCHED_CACHE_EN to add a one-entry result cache.
module muldiv_sched #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,

    input  logic            p0_valid_i,
    output logic            p0_ready_o,
    input  logic [2:0]      p0_op_i,
    input  logic [XLEN-1:0] p0_a_i,
    input  logic [XLEN-1:0] p0_b_i,
    output logic            p0_rsp_valid_o,
    input  logic            p0_rsp_ready_i,
    output logic [XLEN-1:0] p0_rsp_data_o,
    output logic            p0_rsp_err_o,

    input  logic            p1_valid_i,
    output logic            p1_ready_o,
    input  logic [2:0]      p1_op_i,
    input  logic [XLEN-1:0] p1_a_i,
    input  logic [XLEN-1:0] p1_b_i,
    output logic            p1_rsp_valid_o,
    input  logic            p1_rsp_ready_i,
    output logic [XLEN-1:0] p1_rsp_data_o,
    output logic            p1_rsp_err_o,

    output logic            eng_req_o,
    output logic [2:0]      eng_op_o,
    output logic [XLEN-1:0] eng_a_o,
    output logic [XLEN-1:0] eng_b_o,
    input  logic            eng_done_i,
    input  logic [XLEN-1:0] eng_result_i,

    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [2:0]       op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;

    logic             gnt0, gnt1, gnt;
    logic             rsp_take;
    logic             hit;
    logic [2:0]       sel_op;
    logic [XLEN-1:0]  sel_a, sel_b;
    logic [XLEN-1:0]  hit_res;

    // last_q == 1 means port 1 won last, so port 0 wins the next tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && !flush_i) begin
            if (p0_valid_i && p1_valid_i) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = p0_valid_i;
                gnt1 = p1_valid_i;
            end
        end
    end

    assign gnt        = gnt0 | gnt1;
    assign p0_ready_o = gnt0;
    assign p1_ready_o = gnt1;
    assign sel_op     = gnt1 ? p1_op_i : p0_op_i;
    assign sel_a      = gnt1 ? p1_a_i  : p0_a_i;
    assign sel_b      = gnt1 ? p1_b_i  : p0_b_i;
    assign rsp_take   = owner_q ? p1_rsp_ready_i : p0_rsp_ready_i;

`ifdef MULDIV_SCHED_CACHE_EN
    logic            c_vld_q, c_vld_d;
    logic [2:0]      c_op_q, c_op_d;
    logic [XLEN-1:0] c_a_q, c_a_d;
    logic [XLEN-1:0] c_b_q, c_b_d;
    logic [XLEN-1:0] c_res_q, c_res_d;

    always_comb begin
        c_vld_d = c_vld_q;
        c_op_d  = c_op_q;
        c_a_d   = c_a_q;
        c_b_d   = c_b_q;
        c_res_d = c_res_q;
        if (flush_i) begin
            c_vld_d = 1'b0;
        end else if (state_q == BUSY && eng_done_i) begin
            c_vld_d = 1'b1;
            c_op_d  = op_q;
            c_a_d   = a_q;
            c_b_d   = b_q;
            c_res_d = eng_result_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_vld_q <= 1'b0;
            c_op_q  <= '0;
            c_a_q   <= '0;
            c_b_q   <= '0;
            c_res_q <= '0;
        end else begin
            c_vld_q <= c_vld_d;
            c_op_q  <= c_op_d;
            c_a_q   <= c_a_d;
            c_b_q   <= c_b_d;
            c_res_q <= c_res_d;
        end
    end

    assign hit     = c_vld_q && (c_op_q == sel_op)
                     && (c_a_q == sel_a) && (c_b_q == sel_b);
    assign hit_res = c_res_q;
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            IDLE: begin
                if (gnt) begin
                    owner_d = gnt1;
                    last_d  = gnt1;
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    wdog_d  = '0;
                    if (hit) begin
                        res_d   = hit_res;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // flush beats a same-cycle done; done beats the watchdog
                if (flush_i) begin
                    state_d = IDLE;
                end else if (eng_done_i) begin
                    res_d   = eng_result_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wdog_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (flush_i || rsp_take) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign eng_req_o = (state_q == BUSY);
    assign eng_op_o  = op_q;
    assign eng_a_o   = a_q;
    assign eng_b_o   = b_q;

    assign p0_rsp_valid_o = (state_q == RESP) && !owner_q;
    assign p1_rsp_valid_o = (state_q == RESP) && owner_q;
    assign p0_rsp_data_o  = p0_rsp_valid_o ? res_q : '0;
    assign p1_rsp_data_o  = p1_rsp_valid_o ? res_q : '0;
    assign p0_rsp_err_o   = p0_rsp_valid_o & err_q;
    assign p1_rsp_err_o   = p1_rsp_valid_o & err_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized bench for muldiv_sched with a transaction-level model.
// Build with MULDIV_SCHED_CACHE_EN to also expect cache bypasses.
module tb_muldiv_sched;
    localparam int TO = 64;
`ifdef MULDIV_SCHED_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        p0_valid_i = 1'b0, p1_valid_i = 1'b0;
    logic        p0_ready_o, p1_ready_o;
    logic [2:0]  p0_op_i = '0, p1_op_i = '0;
    logic [31:0] p0_a_i = '0, p0_b_i = '0, p1_a_i = '0, p1_b_i = '0;
    logic        p0_rsp_valid_o, p1_rsp_valid_o;
    logic        p0_rsp_ready_i = 1'b0, p1_rsp_ready_i = 1'b0;
    logic [31:0] p0_rsp_data_o, p1_rsp_data_o;
    logic        p0_rsp_err_o, p1_rsp_err_o;
    logic        eng_req_o;
    logic [2:0]  eng_op_o;
    logic [31:0] eng_a_o, eng_b_o;
    logic        eng_done_i = 1'b0;
    logic [31:0] eng_result_i = '0;
    logic        busy_o;

    muldiv_sched #(.XLEN(32), .TIMEOUT_CYC(TO), .CNT_W(7)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .p0_valid_i(p0_valid_i), .p0_ready_o(p0_ready_o),
        .p0_op_i(p0_op_i), .p0_a_i(p0_a_i), .p0_b_i(p0_b_i),
        .p0_rsp_valid_o(p0_rsp_valid_o), .p0_rsp_ready_i(p0_rsp_ready_i),
        .p0_rsp_data_o(p0_rsp_data_o), .p0_rsp_err_o(p0_rsp_err_o),
        .p1_valid_i(p1_valid_i), .p1_ready_o(p1_ready_o),
        .p1_op_i(p1_op_i), .p1_a_i(p1_a_i), .p1_b_i(p1_b_i),
        .p1_rsp_valid_o(p1_rsp_valid_o), .p1_rsp_ready_i(p1_rsp_ready_i),
        .p1_rsp_data_o(p1_rsp_data_o), .p1_rsp_err_o(p1_rsp_err_o),
        .eng_req_o(eng_req_o), .eng_op_o(eng_op_o),
        .eng_a_o(eng_a_o), .eng_b_o(eng_b_o),
        .eng_done_i(eng_done_i), .eng_result_i(eng_result_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    int eng_lat    = 1;
    bit eng_hang   = 1'b0;
    bit force_done = 1'b0;
    int eng_cnt    = 0;
    int req_cnt    = 0;

    // model state: last winner and the one-entry cache contents
    bit          m_last = 1'b1;
    bit          m_cvld = 1'b0;
    logic [2:0]  m_cop  = '0;
    logic [31:0] m_ca = '0, m_cb = '0, m_cres = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mref(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return 32'(ua * ub);
            3'd1: return 32'((sa * sb) >>> 32);
            3'd2: return 32'((sa * longint'(ub)) >>> 32);
            3'd3: return 32'((ua * ub) >> 32);
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // behavioural engine: done pulse after eng_lat request cycles
    always @(negedge clk_i) begin
        eng_done_i = force_done;
        if (eng_req_o) begin
            req_cnt++;
            eng_cnt++;
            if (!eng_hang && eng_cnt == eng_lat) begin
                eng_done_i   = 1'b1;
                eng_result_i = mref(eng_op_o, eng_a_o, eng_b_o);
            end
        end else begin
            eng_cnt = 0;
        end
    end

    // lat == 0 means the engine never answers
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                           input int lat, input int hold);
        bit port, hit, exp_e, got_e;
        logic [2:0] op;
        logic [31:0] a, b, exp_d, got_d;
        int n, exp_n, exp_req;
        @(posedge clk_i); #1;
        eng_lat  = lat;
        eng_hang = (lat == 0);
        p0_valid_i = v0; p0_op_i = op0; p0_a_i = a0; p0_b_i = b0;
        p1_valid_i = v1; p1_op_i = op1; p1_a_i = a1; p1_b_i = b1;
        port = (v0 && v1) ? !m_last : !v0;
        op = port ? op1 : op0;
        a  = port ? a1 : a0;
        b  = port ? b1 : b0;
        hit = CACHE && m_cvld && m_cop == op && m_ca == a && m_cb == b;
        if (hit) begin
            exp_d = m_cres; exp_e = 1'b0; exp_n = 1; exp_req = 0;
        end else if (lat == 0) begin
            exp_d = 32'd0; exp_e = 1'b1; exp_n = TO + 1; exp_req = TO;
        end else begin
            exp_d = mref(op, a, b); exp_e = 1'b0; exp_n = lat + 1; exp_req = lat;
        end
        @(negedge clk_i);
        check("grant", {p1_ready_o, p0_ready_o}, port ? 2'b10 : 2'b01);
        @(posedge clk_i); #1;
        p0_valid_i = 1'b0;
        p1_valid_i = 1'b0;
        req_cnt = 0;
        m_last = port;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (n < TO + 20 && !(p0_rsp_valid_o || p1_rsp_valid_o));
        if (!(p0_rsp_valid_o || p1_rsp_valid_o)) begin
            check("rsp_seen", 0, 1);
            return;
        end
        check("rsp_port", {p1_rsp_valid_o, p0_rsp_valid_o}, port ? 2'b10 : 2'b01);
        check("rsp_lat", n, exp_n);
        check("eng_req_cyc", req_cnt, exp_req);
        got_d = port ? p1_rsp_data_o : p0_rsp_data_o;
        got_e = port ? p1_rsp_err_o : p0_rsp_err_o;
        check("rsp_data", got_d, exp_d);
        check("rsp_err", got_e, exp_e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            p0_valid_i = 1'b1; p0_a_i = $urandom;
            p1_valid_i = 1'b1; p1_a_i = $urandom;
            @(negedge clk_i);
            check("hold_data", port ? p1_rsp_data_o : p0_rsp_data_o, exp_d);
            check("hold_err", port ? p1_rsp_err_o : p0_rsp_err_o, exp_e);
            check("hold_ready", {p1_ready_o, p0_ready_o}, 2'b00);
        end
        @(posedge clk_i); #1;
        p0_valid_i = 1'b0;
        p1_valid_i = 1'b0;
        if (port) p1_rsp_ready_i = 1'b1;
        else      p0_rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        p0_rsp_ready_i = 1'b0;
        p1_rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check("idle_busy", busy_o, 0);
        check("idle_rsp", {p1_rsp_valid_o, p0_rsp_valid_o}, 2'b00);
        check("idle_req", eng_req_o, 0);
        if (!exp_e) begin
            m_cvld = 1'b1; m_cop = op; m_ca = a; m_cb = b; m_cres = exp_d;
        end
        eng_hang = 1'b0;
    endtask

    // same == 1 lines the engine done up with the flush cycle
    task automatic flush_test(input bit same);
        @(posedge clk_i); #1;
        eng_hang = !same;
        eng_lat  = 3;
        p0_valid_i = 1'b1; p1_valid_i = 1'b0;
        p0_op_i = 3'd0; p0_a_i = 32'd3; p0_b_i = 32'd5;
        @(negedge clk_i);
        check("flush_grant", {p1_ready_o, p0_ready_o}, 2'b01);
        @(posedge clk_i); #1;
        p0_valid_i = 1'b0;
        m_last = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_busy_before", busy_o, 1);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        force_done = !same;
        m_cvld = 1'b0;
        @(negedge clk_i);
        check("flush_req_drop", eng_req_o, 0);
        check("flush_idle", busy_o, 0);
        @(posedge clk_i); #1;
        force_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("flush_no_rsp", {p1_rsp_valid_o, p0_rsp_valid_o, busy_o}, 3'b000);
        end
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        p0_valid_i = 1'b1;
        p1_valid_i = 1'b1;
        @(negedge clk_i);
        check("flush_idle_nogrant", {p1_ready_o, p0_ready_o}, 2'b00);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        p0_valid_i = 1'b0;
        p1_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_idle_stay", busy_o, 0);
        eng_hang = 1'b0;
    endtask

    task automatic reset_mid_op();
        @(posedge clk_i); #1;
        eng_hang = 1'b1;
        p1_valid_i = 1'b1; p1_op_i = 3'd1; p1_a_i = 32'd9; p1_b_i = 32'd4;
        @(posedge clk_i); #1;
        p1_valid_i = 1'b0;
        check("arst_pre_req", eng_req_o, 1);
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        #1;
        check("arst_req", eng_req_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_ops", eng_a_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_last = 1'b1;
        m_cvld = 1'b0;
        eng_hang = 1'b0;
    endtask

    initial begin
        bit rv0, rv1;
        logic [2:0] ro0, ro1;
        logic [31:0] ra0, rb0, ra1, rb1;
        #3;
        check("rst_req", eng_req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_rsp_valid", {p1_rsp_valid_o, p0_rsp_valid_o}, 2'b00);
        check("rst_ready", {p1_ready_o, p0_ready_o}, 2'b00);
        check("rst_rsp_data", {p1_rsp_data_o, p0_rsp_data_o}, 64'd0);
        check("rst_eng_ops", {eng_op_o, eng_a_o, eng_b_o}, 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 3; i++)
            run_txn(1'b1, 1'b1, 3'd0, 32'd2 + 32'(i), 32'd3,
                    3'd3, 32'd100, 32'd5 + 32'(i), 2, 0);
        run_txn(1'b1, 1'b0, 3'd0, 32'd7, 32'd6, 3'd0, 32'd0, 32'd0, 5, 0);
        run_txn(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 3'd4, 32'd50, 32'd3, 0, 0);
        flush_test(1'b0);
        flush_test(1'b1);
        run_txn(1'b1, 1'b0, 3'd7, 32'd77, 32'd10, 3'd0, 32'd0, 32'd0, 3, 10);
        run_txn(1'b1, 1'b0, 3'd5, 32'd100, 32'd7, 3'd0, 32'd0, 32'd0, 4, 0);
        run_txn(1'b1, 1'b0, 3'd5, 32'd100, 32'd7, 3'd0, 32'd0, 32'd0, 4, 0);
        run_txn(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 3'd6, 32'hFFFF_FF9C, 32'd7, 3, 1);
        run_txn(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 3'd4, 32'hFFFF_FF9C, 32'd7, 3, 0);
        reset_mid_op();

        for (int i = 0; i < 40; i++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) rv0 = 1'b1;
            ro0 = 3'($urandom_range(0, 7)); ra0 = rnd_val(); rb0 = rnd_val();
            ro1 = 3'($urandom_range(0, 7)); ra1 = rnd_val(); rb1 = rnd_val();
            if (m_cvld && $urandom_range(0, 3) == 0) begin
                ro0 = m_cop; ra0 = m_ca; rb0 = m_cb;
                ro1 = m_cop; ra1 = m_ca; rb1 = m_cb;
            end
            run_txn(rv0, rv1, ro0, ra0, rb0, ro1, ra1, rb1,
                    $urandom_range(1, 8), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Sequencer/arbiter sharing one iterative M-extension engine (mul/div datapath) between two requesters, e.g. pipeline EX stage (port 0) and a debug/accelerator path (port 1).
- Accepts one operation at a time and holds engine request and operands stable until completion.
- Routes the result back to the winning requester over a valid/ready response channel.
- Adds round-robin fairness, flush abort and a completion watchdog.

Parameters:
- XLEN, 32, operand/result width.
- TIMEOUT_CYC, 64, max engine cycles per operation before watchdog abort; must be ≥ 2.
- CNT_W, 7, watchdog counter width; must hold TIMEOUT_CYC.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush; aborts the in-flight op.
- p0_valid_i  in  1  port 0 request valid.
- p0_ready_o  out  1  port 0 request accepted this cycle.
- p0_op_i  in  3  funct3 of the M op (MUL..REMU encoding).
- p0_a_i  in  XLEN  rs1 operand.
- p0_b_i  in  XLEN  rs2 operand.
- p0_rsp_valid_o  out  1  port 0 result valid.
- p0_rsp_ready_i  in  1  port 0 result taken.
- p0_rsp_data_o  out  XLEN  result.
- p0_rsp_err_o  out  1  watchdog abort flag.
- p1_valid_i, p1_ready_o, p1_op_i, p1_a_i, p1_b_i, p1_rsp_valid_o, p1_rsp_ready_i, p1_rsp_data_o, p1_rsp_err_o: same directions, widths and meanings as the p0_* ports, for port 1.
- eng_req_o  out  1  engine request, level held.
- eng_op_o  out  3  funct3 to engine.
- eng_a_o  out  XLEN  operand a.
- eng_b_o  out  XLEN  operand b.
- eng_done_i  in  1  engine result valid, one-cycle pulse.
- eng_result_i  in  XLEN  engine result.
- busy_o  out  1  FSM not IDLE.

Behaviour:
- Clocking/reset: one clock `clk_i`; reset `rst_ni` is asynchronous, active-low.
- Reset values: all outputs 0; FSM=IDLE; last_grant=1, so port 0 wins the first contention; watchdog=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Arbitrate among asserted p*_valid_i.
  - One valid: grant it.
  - Both valid: grant the port != last_grant.
  - Granted port sees pX_ready_o=1 combinationally in that cycle (the only cycle ready may be high).
  - Capture op/a/b into holding flops, set owner and last_grant, go BUSY.
  - flush_i=1 in IDLE: no grant.
- BUSY:
  - eng_req_o=1; eng_op_o/eng_a_o/eng_b_o driven from holding flops, stable for the whole state.
  - Watchdog increments each BUSY cycle.
  - eng_done_i=1: capture eng_result_i, err=0, go RESP; eng_req_o drops the next cycle.
  - Watchdog reaches TIMEOUT_CYC-1 with no done: data=0, err=1, go RESP.
  - flush_i=1: go IDLE with no response; eng_req_o deasserts the next cycle (engine treats request deassert as abort).
  - flush_i and eng_done_i in the same cycle: flush wins; result discarded.
- RESP:
  - Owner's rsp_valid_o=1 with registered data/err; other port's rsp_valid_o=0.
  - Data/err stable until owner's rsp_ready_i=1, then IDLE next cycle.
  - flush_i=1 in RESP: drop response, go IDLE.
- Throughput: at most one op per (engine latency + 2) cycles.
  - Minimum latency accept→rsp_valid = engine latency + 1 cycle.
  - No new acceptance in BUSY or RESP.
- eng_done_i outside BUSY: ignored.
- Watchdog clears on every entry to BUSY.
- rst_ni low mid-operation: immediate return to reset values; eng_req_o drops asynchronously.
- Operands pass through unmodified; sign pre/post adjustment stays in the engine-side logic.

Optional Feature:
- Macro: MULDIV_SCHED_CACHE_EN.
- When defined: a one-entry result cache (valid, op, a, b, result) loads on every non-error completion.
  - A new grant whose op/a/b match a valid entry bypasses the engine: IDLE→RESP directly with the cached data, err=0; eng_req_o never asserts.
  - Entry invalidated on reset and on flush_i.
  - Paired ops share no entry: DIV after REM, same operands, is a miss.
- When undefined: no cache storage; every op goes through the engine.

Test Plan:
- Port0 MUL a=7 b=6, engine done after 5 cycles with 42 → eng_req_o high 5 cycles; p0_rsp_valid_o with data=42, err=0; idle after rsp_ready.
- Both ports valid from reset → port0 granted first; port1 granted on next IDLE; third contention goes to port0.
- Engine never pulses done, TIMEOUT_CYC=64 → RESP after 64 BUSY cycles with err=1, data=0; eng_req_o low afterwards.
- flush_i asserted 3 cycles into BUSY, eng_done_i 1 cycle later → no rsp_valid on either port; FSM IDLE; done ignored.
- rsp_ready_i held low 10 cycles in RESP → data/err stable; no p*_ready_o during that time.
- CACHE_EN: DIVU 100/7 twice back-to-back → second response data=14 with 0 engine-request cycles, one cycle after grant.
